// File: rtl/gshare_predictor_pkg.sv
// Shared configuration and types for the gshare branch predictor.
// Holds the default history and index widths, the counter width and the
// commit-time update record that travels from the ROB to the predictor.
package gshare_predictor_pkg;

  localparam int unsigned GLOBAL_HISTORY_LEN  = 4;
  localparam int unsigned PC_IDX_LEN          = 4;
  localparam int unsigned PATTERN_HISTORY_LEN = GLOBAL_HISTORY_LEN + PC_IDX_LEN;
  localparam int unsigned BP_CTR_BITS         = 2;

  // Commit-side training record for a retiring conditional branch.
  typedef struct packed {
    logic                           valid;
    logic [PATTERN_HISTORY_LEN-1:0] pht_idx;
    logic                           taken;
    logic                           mispredict;
  } bp_update_t;

endpackage

// File: rtl/gshare_pht.sv
// Pattern history table: an array of saturating counters.
// Ports:
//   clk, rst       clock, asynchronous active-low reset
//   rd_idx/rd_ctr  combinational read port (prediction)
//   wr_en/wr_idx/wr_taken  saturating read-modify-write port (commit training)
// Every counter resets to weakly not-taken. A same-cycle read of the entry
// being written returns the pre-update value.
module gshare_pht
  import gshare_predictor_pkg::*;
#(
  parameter int unsigned IdxLen  = PATTERN_HISTORY_LEN,
  parameter int unsigned CtrBits = BP_CTR_BITS
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [IdxLen-1:0]  rd_idx,
  output logic [CtrBits-1:0] rd_ctr,
  input  logic               wr_en,
  input  logic [IdxLen-1:0]  wr_idx,
  input  logic               wr_taken
);

  localparam int unsigned        Entries = 2 ** IdxLen;
  // Weakly not-taken: 2^(CtrBits-1)-1 (evaluates to 0 for 1-bit counters).
  localparam logic [CtrBits-1:0] CtrInit = CtrBits'((1 << (CtrBits - 1)) - 1);
  localparam logic [CtrBits-1:0] CtrMax  = '1;

  logic [CtrBits-1:0] pht_q [Entries];
  logic [CtrBits-1:0] pht_d [Entries];
  logic [CtrBits-1:0] wr_ctr;

  assign rd_ctr = pht_q[rd_idx];

  always_comb begin
    pht_d  = pht_q;
    wr_ctr = pht_q[wr_idx];
    if (wr_en) begin
      if (wr_taken) begin
        if (wr_ctr != CtrMax) pht_d[wr_idx] = wr_ctr + CtrBits'(1);
      end else begin
        if (wr_ctr != '0) pht_d[wr_idx] = wr_ctr - CtrBits'(1);
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < Entries; i++) pht_q[i] <= CtrInit;
    end else begin
      pht_q <= pht_d;
    end
  end

endmodule

// File: rtl/gshare_predictor.sv
// gshare conditional-branch predictor for the fetch stage.
// Ports:
//   clk, rst            clock, asynchronous active-low reset
//   pred_*              fetch-side lookup: same-cycle direction, PHT index and counter
//   commit_*            ROB-commit training and mispredict history repair
//   perf_branches, perf_mispredicts  saturating event counters, present only
//                       when BP_PERF_CTR_EN is defined
// Index = {spec_ghr, pc[PC_IDX_LEN+1:2]}. The speculative GHR shifts on each
// fetched branch; on a committed mispredict it is rebuilt from the
// architectural GHR, overriding any same-cycle speculative shift.
module gshare_predictor #(
  parameter int unsigned GLOBAL_HISTORY_LEN = gshare_predictor_pkg::GLOBAL_HISTORY_LEN,
  parameter int unsigned PC_IDX_LEN         = gshare_predictor_pkg::PC_IDX_LEN,
  parameter int unsigned CTR_BITS           = gshare_predictor_pkg::BP_CTR_BITS,
  parameter int unsigned PHT_IDX_LEN        = GLOBAL_HISTORY_LEN + PC_IDX_LEN
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   pred_valid,
  input  logic                   pred_is_branch,
  input  logic [31:0]            pred_pc,
  output logic                   pred_taken,
  output logic [PHT_IDX_LEN-1:0] pred_pht_idx,
  output logic [CTR_BITS-1:0]    pred_ctr,
`ifdef BP_PERF_CTR_EN
  output logic [31:0]            perf_branches,
  output logic [31:0]            perf_mispredicts,
`endif
  input  logic                   commit_valid,
  input  logic [PHT_IDX_LEN-1:0] commit_pht_idx,
  input  logic                   commit_taken,
  input  logic                   commit_mispredict
);

  import gshare_predictor_pkg::*;

  logic [GLOBAL_HISTORY_LEN-1:0] spec_ghr_q, spec_ghr_d;
  logic [GLOBAL_HISTORY_LEN-1:0] arch_ghr_q, arch_ghr_d;

  // Only pc[PC_IDX_LEN+1:2] feeds the index.
  logic unused_pc_bits;
  assign unused_pc_bits = ^{pred_pc[31:PC_IDX_LEN+2], pred_pc[1:0]};

  assign pred_pht_idx = {spec_ghr_q, pred_pc[PC_IDX_LEN+1:2]};
  assign pred_taken   = pred_ctr[CTR_BITS-1] & pred_is_branch;

  gshare_pht #(
    .IdxLen  (PHT_IDX_LEN),
    .CtrBits (CTR_BITS)
  ) u_pht (
    .clk      (clk),
    .rst      (rst),
    .rd_idx   (pred_pht_idx),
    .rd_ctr   (pred_ctr),
    .wr_en    (commit_valid),
    .wr_idx   (commit_pht_idx),
    .wr_taken (commit_taken)
  );

  // Truncating {ghr, bit} keeps the low bits, which also covers a 1-bit GHR.
  always_comb begin
    arch_ghr_d = arch_ghr_q;
    spec_ghr_d = spec_ghr_q;
    if (commit_valid) begin
      arch_ghr_d = GLOBAL_HISTORY_LEN'({arch_ghr_q, commit_taken});
    end
    if (pred_valid && pred_is_branch) begin
      spec_ghr_d = GLOBAL_HISTORY_LEN'({spec_ghr_q, pred_taken});
    end
    if (commit_valid && commit_mispredict) begin
      spec_ghr_d = arch_ghr_d;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      spec_ghr_q <= '0;
      arch_ghr_q <= '0;
    end else begin
      spec_ghr_q <= spec_ghr_d;
      arch_ghr_q <= arch_ghr_d;
    end
  end

`ifdef BP_PERF_CTR_EN
  logic [31:0] perf_branches_q, perf_branches_d;
  logic [31:0] perf_mispredicts_q, perf_mispredicts_d;

  always_comb begin
    perf_branches_d    = perf_branches_q;
    perf_mispredicts_d = perf_mispredicts_q;
    if (commit_valid && (perf_branches_q != 32'hFFFF_FFFF)) begin
      perf_branches_d = perf_branches_q + 32'd1;
    end
    if (commit_valid && commit_mispredict && (perf_mispredicts_q != 32'hFFFF_FFFF)) begin
      perf_mispredicts_d = perf_mispredicts_q + 32'd1;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      perf_branches_q    <= '0;
      perf_mispredicts_q <= '0;
    end else begin
      perf_branches_q    <= perf_branches_d;
      perf_mispredicts_q <= perf_mispredicts_d;
    end
  end

  assign perf_branches    = perf_branches_q;
  assign perf_mispredicts = perf_mispredicts_q;
`endif

endmodule

// File: tb/tb_gshare_predictor.sv
// Scoreboard bench for gshare_predictor (default parameters: 4-bit GHR,
// 4 PC bits, 2-bit counters, 8-bit index). Stimulus pushes the expected
// prediction for every pred_valid cycle; a monitor pops and compares.
module tb_gshare_predictor;

  localparam logic [31:0] P4 = 32'h6000_0010;  // pc[5:2] = 4
  localparam logic [31:0] PA = 32'h6000_0028;  // pc[5:2] = A

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        pred_valid = 1'b0;
  logic        pred_is_branch = 1'b0;
  logic [31:0] pred_pc = '0;
  logic        pred_taken;
  logic [7:0]  pred_pht_idx;
  logic [1:0]  pred_ctr;
  logic        commit_valid = 1'b0;
  logic [7:0]  commit_pht_idx = '0;
  logic        commit_taken = 1'b0;
  logic        commit_mispredict = 1'b0;
`ifdef BP_PERF_CTR_EN
  logic [31:0] perf_branches;
  logic [31:0] perf_mispredicts;
`endif

  gshare_predictor dut (
    .clk               (clk),
    .rst               (rst),
    .pred_valid        (pred_valid),
    .pred_is_branch    (pred_is_branch),
    .pred_pc           (pred_pc),
    .pred_taken        (pred_taken),
    .pred_pht_idx      (pred_pht_idx),
    .pred_ctr          (pred_ctr),
`ifdef BP_PERF_CTR_EN
    .perf_branches     (perf_branches),
    .perf_mispredicts  (perf_mispredicts),
`endif
    .commit_valid      (commit_valid),
    .commit_pht_idx    (commit_pht_idx),
    .commit_taken      (commit_taken),
    .commit_mispredict (commit_mispredict)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [7:0] idx;
    logic [1:0] ctr;
    logic       tk;
    string      name;
  } exp_t;

  exp_t sb_q[$];
  int   checks = 0;
  int   errors = 0;

  // One cycle of stimulus, driven on the falling edge.
  task automatic step(input logic pv, input logic pb, input logic [31:0] pc,
                      input logic cv, input logic [7:0] cidx, input logic ct,
                      input logic cm, input logic [7:0] e_idx, input logic [1:0] e_ctr,
                      input logic e_tk, input string name);
    exp_t e;
    @(negedge clk);
    pred_valid        = pv;
    pred_is_branch    = pb;
    pred_pc           = pc;
    commit_valid      = cv;
    commit_pht_idx    = cidx;
    commit_taken      = ct;
    commit_mispredict = cm;
    if (pv) begin
      e.idx  = e_idx;
      e.ctr  = e_ctr;
      e.tk   = e_tk;
      e.name = name;
      sb_q.push_back(e);
    end
  endtask

  task automatic idle();
    step(1'b0, 1'b0, '0, 1'b0, '0, 1'b0, 1'b0, '0, '0, 1'b0, "idle");
  endtask

  // Monitor: samples 2 time units after the falling edge.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      #2;
      if (pred_valid) begin
        if (sb_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL scoreboard_underflow: prediction with no expected entry");
        end else begin
          e = sb_q.pop_front();
          checks++;
          if (pred_pht_idx !== e.idx) begin
            errors++;
            $display("FAIL %s idx: got %02h want %02h", e.name, pred_pht_idx, e.idx);
          end
          checks++;
          if (pred_ctr !== e.ctr) begin
            errors++;
            $display("FAIL %s ctr: got %b want %b", e.name, pred_ctr, e.ctr);
          end
          checks++;
          if (pred_taken !== e.tk) begin
            errors++;
            $display("FAIL %s taken: got %b want %b", e.name, pred_taken, e.tk);
          end
        end
      end
    end
  end

  initial begin
    #12;
    @(negedge clk);
    rst = 1'b1;

    // Reset state and training of idx 04 (collision, increment, saturate).
    step(1, 1, P4, 0, 8'h00, 0, 0, 8'h04, 2'b01, 0, "reset_pred");
    step(1, 0, P4, 1, 8'h04, 1, 0, 8'h04, 2'b01, 0, "collision_pre");
    step(1, 0, P4, 1, 8'h04, 1, 0, 8'h04, 2'b10, 0, "train_10");
    step(1, 0, P4, 1, 8'h04, 1, 0, 8'h04, 2'b11, 0, "train_11");
    step(1, 0, P4, 0, 8'h00, 0, 0, 8'h04, 2'b11, 0, "sat_nonbranch");
    step(1, 1, P4, 0, 8'h00, 0, 0, 8'h04, 2'b11, 1, "taken_pred");
    // spec_ghr = 0001: not-taken training of fresh idx 1A.
    step(1, 0, PA, 1, 8'h1A, 0, 0, 8'h1A, 2'b01, 0, "nt_pre");
    step(1, 0, PA, 1, 8'h1A, 0, 0, 8'h1A, 2'b00, 0, "nt_00a");
    step(1, 0, PA, 1, 8'h1A, 0, 0, 8'h1A, 2'b00, 0, "nt_00b");
    step(1, 1, PA, 0, 8'h00, 0, 0, 8'h1A, 2'b00, 0, "nt_00c");
    step(1, 0, P4, 0, 8'h00, 0, 0, 8'h24, 2'b01, 0, "ghr_0010");

    // Asynchronous reset with a commit in flight: the update is lost.
    @(negedge clk);
    pred_valid     = 1'b0;
    commit_valid   = 1'b1;
    commit_pht_idx = 8'h04;
    commit_taken   = 1'b1;
    #2 rst = 1'b0;
    @(negedge clk);
    commit_valid = 1'b0;
    rst = 1'b1;
    step(1, 0, P4, 0, 8'h00, 0, 0, 8'h04, 2'b01, 0, "post_reset");

    // Build spec_ghr = 0011, then repair on a mispredict.
    step(0, 0, P4, 1, 8'h04, 1, 0, 8'h00, 2'b00, 0, "c1");
    step(0, 0, P4, 1, 8'h14, 1, 0, 8'h00, 2'b00, 0, "c2");
    step(1, 1, P4, 0, 8'h00, 0, 0, 8'h04, 2'b10, 1, "mp_pred1");
    step(1, 1, P4, 0, 8'h00, 0, 0, 8'h14, 2'b10, 1, "mp_pred2");
    step(1, 0, P4, 0, 8'h00, 0, 0, 8'h34, 2'b01, 0, "ghr_0011");
    // Speculative shift would give 0110; repair gives shift(0011,1) = 0111.
    step(1, 1, P4, 1, 8'h14, 1, 1, 8'h34, 2'b01, 0, "mp_flush");
    step(1, 0, P4, 0, 8'h00, 0, 0, 8'h74, 2'b01, 0, "ghr_repaired");
    step(1, 0, P4, 0, 8'h00, 0, 1, 8'h74, 2'b01, 0, "cm_no_valid");
    step(1, 0, P4, 0, 8'h00, 0, 0, 8'h74, 2'b01, 0, "cm_ignored");
    step(0, 0, P4, 1, 8'h00, 0, 1, 8'h00, 2'b00, 0, "c10");
    step(0, 0, P4, 1, 8'h00, 0, 0, 8'h00, 2'b00, 0, "c11");
    step(1, 0, P4, 0, 8'h00, 0, 0, 8'hE4, 2'b01, 0, "ghr_1110");

`ifdef BP_PERF_CTR_EN
    #1;
    checks++;
    if (perf_branches !== 32'd5) begin
      errors++;
      $display("FAIL perf_branches: got %0d want 5", perf_branches);
    end
    checks++;
    if (perf_mispredicts !== 32'd2) begin
      errors++;
      $display("FAIL perf_mispredicts: got %0d want 2", perf_mispredicts);
    end
    #1 rst = 1'b0;
    #1;
    checks++;
    if (perf_branches !== 32'd0 || perf_mispredicts !== 32'd0) begin
      errors++;
      $display("FAIL perf_async_reset: got %0d/%0d want 0/0", perf_branches,
               perf_mispredicts);
    end
    @(negedge clk);
    rst = 1'b1;
`endif

    idle();
    idle();
    @(negedge clk);
    #3;
    checks++;
    if (sb_q.size() != 0) begin
      errors++;
      $display("FAIL scoreboard_drain: %0d entries left, want 0", sb_q.size());
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/gshare_predictor.md
# gshare_predictor

Parametrised gshare conditional-branch predictor for the out-of-order core's fetch stage. It provides a same-cycle direction prediction plus the pattern-history-table (PHT) index and counter value, which travel with the instruction in the instruction queue and ROB. It keeps a speculative global history register (GHR) and an architectural GHR. At ROB commit it trains the counters and repairs the speculative history after a mispredict.

## Interface
- GLOBAL_HISTORY_LEN, default 4: GHR width in bits; must be ≥1.
- PC_IDX_LEN, default 4: number of PC bits used in the index (pc[PC_IDX_LEN+1:2]); must be ≥1.
- CTR_BITS, default 2: saturating counter width; must be ≥1.
- PHT_IDX_LEN, default GLOBAL_HISTORY_LEN+PC_IDX_LEN: derived, giving 2^PHT_IDX_LEN entries.
- clk  in  1  sole clock; everything samples on the rising edge.
- rst  in  1  asynchronous, active-low reset.
- pred_valid  in  1  fetch presents an instruction this cycle.
- pred_is_branch  in  1  predecoded conditional branch (op_b_br).
- pred_pc  in  32  PC of the fetched instruction.
- pred_taken  out  1  predicted direction.
- pred_pht_idx  out  PHT_IDX_LEN  index used for this prediction.
- pred_ctr  out  CTR_BITS  counter value read for this prediction.
- commit_valid  in  1  ROB head is retiring a conditional branch.
- commit_pht_idx  in  PHT_IDX_LEN  index carried with the branch.
- commit_taken  in  1  resolved outcome (br_en).
- commit_mispredict  in  1  resolved direction differs from the prediction; the front end flushes.
- With BP_PERF_CTR_EN: perf_branches  out  32, perf_mispredicts  out  32.

## Operation
- Index: pred_pht_idx = {spec_ghr, pred_pc[PC_IDX_LEN+1:2]}, concatenated with the GHR in the upper bits.
- Counter read: pred_ctr = pht[pred_pht_idx].
- Direction: pred_taken = pred_ctr[CTR_BITS-1] AND pred_is_branch, so non-branches always predict not-taken.
- Speculative history: when pred_valid && pred_is_branch, spec_ghr <= {spec_ghr[GLOBAL_HISTORY_LEN-2:0], pred_taken}. For GLOBAL_HISTORY_LEN=1 the register is simply replaced by pred_taken.
- Architectural history: when commit_valid, arch_ghr <= shift-in of commit_taken.
- Counter training on commit_valid is a read-modify-write on the current pht[commit_pht_idx], not on a carried value:
  - taken: increment, saturating at 2^CTR_BITS−1.
  - not taken: decrement, saturating at 0.
- Mispredict repair: when commit_valid && commit_mispredict, spec_ghr <= shift(arch_ghr, commit_taken). This is the same value arch_ghr takes that cycle.
- Priority: the mispredict repair overrides a same-cycle speculative shift. That cycle's fetch is being flushed, so its prediction outputs are don't-care for history.
- commit_mispredict without commit_valid is ignored.
- Same-index collision (predict and commit to one entry in the same cycle): the prediction returns the pre-update value, and the update lands at the edge. There is no bypass.
- Reset values:
  - every PHT entry = 2^(CTR_BITS−1)−1, i.e. weakly not-taken (01 for 2-bit counters).
  - spec_ghr = 0, arch_ghr = 0.
  - perf counters = 0.
- Reset asserted mid-operation clears all state immediately; an update in flight is lost.

## Timing
- Prediction is combinational from registered state, with 0-cycle latency.
- PHT, GHR and perf-counter updates are visible in the cycle after the qualifying edge.
- There is no handshake or backpressure. Inputs are sampled only when their valid is high.
- Back-to-back commits to one index each see the previous cycle's written value.

## Configuration
- BP_PERF_CTR_EN defined:
  - perf_branches increments on each commit_valid.
  - perf_mispredicts increments on commit_valid && commit_mispredict.
  - Both are 32-bit, saturate at 0xFFFF_FFFF, and are reset to 0.
- BP_PERF_CTR_EN undefined: both ports and both counters are absent, and predictor behaviour is identical.

## Structure
- The params package holds GLOBAL_HISTORY_LEN, PC_IDX_LEN, PATTERN_HISTORY_LEN (= PHT_IDX_LEN) and a new BP_CTR_BITS.
- rv32i_types holds a new bp_update_t struct: valid, pht_idx, taken, mispredict.
- The PHT index and counter carried with each instruction match inst_queue_t.branch_pht_idx / branch_pht_prediction and rob_entry_t.pht_idx / prediction_val.
- One sub-module is natural: gshare_pht. It holds the counter array, with one combinational read port, one saturating read-modify-write port and the reset initialisation. The top level keeps the GHRs, indexing and perf counters.

## Test plan
- Reset, then pred_valid=1, pred_is_branch=1, pc=0x6000_0010 → pred_pht_idx=0x04, pred_ctr=01, pred_taken=0; the next cycle spec_ghr=0.
- Three taken commits to idx 0x04 → ctr goes 10, 11, 11 (saturates). A later prediction at that idx, with spec_ghr=0 and pc=0x6000_0010, gives pred_taken=1.
- Three not-taken commits to a fresh idx → ctr goes 00, 00, 00, and pred_taken stays 0.
- Predict two branches taken, so spec_ghr=0011. Then commit one branch with commit_taken=0 and commit_mispredict=1 → spec_ghr=arch_ghr=0000. A same-cycle speculative shift is discarded.
- Same-cycle predict and commit-taken to idx 0x04 holding ctr=01 → pred_ctr=01 that cycle, and a re-read the next cycle gives 10.
- With BP_PERF_CTR_EN: 5 commits, 2 of them mispredicts → perf_branches=5, perf_mispredicts=2. Asserting rst mid-stream zeroes both counters asynchronously.
